// File: rtl/crossroad_request_detector_if.sv
// Sensor and controller handshake bundle for the crossroad request detector.
// The master side drives the raw sensor, tick and grant; the slave side returns the conditioned status.
interface crossroad_request_detector_if;
  logic       sensor_in;
  logic       tick;
  logic       grant;
  logic       sensor_clean;
  logic       request;
  logic [2:0] pending_count;
  logic       holdoff;

  modport master (
    output sensor_in, tick, grant,
    input  sensor_clean, request, pending_count, holdoff
  );

  modport slave (
    input  sensor_in, tick, grant,
    output sensor_clean, request, pending_count, holdoff
  );
endinterface

// File: rtl/crossroad_request_detector.sv
// Synchronises and debounces the crossroad sensor, counts arrivals and runs the
// request / serve / hold-off handshake with the traffic light controller.
module crossroad_request_detector #(
  parameter int unsigned DB_COUNT      = 15,
  parameter int unsigned DB_W          = 8,
  parameter int unsigned HOLDOFF_TICKS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  crossroad_request_detector_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVE, HOLDOFF} state_t;

  logic            sync1, sync2;
  logic [DB_W-1:0] db_cnt;
  logic            clean, clean_q;
  logic            rise;
  state_t          state;
  logic [2:0]      pend;
  logic [3:0]      ho_cnt;
  logic            request_q, holdoff_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      db_cnt  <= '0;
      clean   <= 1'b0;
      clean_q <= 1'b0;
    end else begin
      sync1   <= bus.sensor_in;
      sync2   <= sync1;
      clean_q <= clean;
      if (sync2 == clean) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_COUNT - 1)) begin
        clean  <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign rise = clean & ~clean_q;

  // The REQ->SERVE clear is written after the increment so it wins on a simultaneous rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pend      <= '0;
      ho_cnt    <= '0;
      request_q <= 1'b0;
      holdoff_q <= 1'b0;
    end else begin
      if (rise && state != SERVE && pend != 3'd7)
        pend <= pend + 3'd1;
      case (state)
        IDLE: begin
          if (rise) begin
            state     <= REQ;
            request_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.grant) begin
            state     <= SERVE;
            request_q <= 1'b0;
            pend      <= '0;
          end
        end
        SERVE: begin
          if (!bus.grant) begin
            if (HOLDOFF_TICKS != 0) begin
              state     <= HOLDOFF;
              holdoff_q <= 1'b1;
              ho_cnt    <= 4'(HOLDOFF_TICKS);
            end else if (pend != 3'd0) begin
              state     <= REQ;
              request_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLDOFF: begin
          if (bus.tick) begin
            ho_cnt <= ho_cnt - 4'd1;
            if (ho_cnt == 4'd1) begin
              holdoff_q <= 1'b0;
              if (pend != 3'd0 || rise) begin
                state     <= REQ;
                request_q <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          request_q <= 1'b0;
          holdoff_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sensor_clean  = clean;
  assign bus.request       = request_q;
  assign bus.pending_count = pend;
  assign bus.holdoff       = holdoff_q;

endmodule

// File: tb/tb_crossroad_request_detector.sv
// Directed scoreboard bench: one detector with a 3-tick hold-off and one with hold-off disabled.
module tb_crossroad_request_detector;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hb_seen = 1'b0;

  always #5 clk = ~clk;

  crossroad_request_detector_if bus_a ();
  crossroad_request_detector_if bus_b ();

  crossroad_request_detector #(.DB_COUNT(15), .DB_W(8), .HOLDOFF_TICKS(3)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  crossroad_request_detector #(.DB_COUNT(3), .DB_W(4), .HOLDOFF_TICKS(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  always @(posedge clk) if (bus_b.holdoff === 1'b1) hb_seen <= 1'b1;

  typedef struct {
    string      tag;
    int         sel;
    logic [5:0] exp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected vector is {sensor_clean, request, pending_count, holdoff}.
  task automatic expect_out(input string tag, input int sel, input logic clean,
                            input logic req, input logic [2:0] pend, input logic ho);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = {clean, req, pend, ho};
    q.push_back(e);
  endtask

  task automatic compare_all();
    exp_t e;
    logic [5:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0:       obs = {bus_a.sensor_clean, bus_a.request, bus_a.pending_count, bus_a.holdoff};
        1:       obs = {bus_b.sensor_clean, bus_b.request, bus_b.pending_count, bus_b.holdoff};
        default: obs = {5'b0, hb_seen};
      endcase
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic press_a();
    bus_a.sensor_in = 1'b1;
    step(20);
    bus_a.sensor_in = 1'b0;
    step(20);
  endtask

  task automatic tick_a();
    bus_a.tick = 1'b1;
    step(1);
    bus_a.tick = 1'b0;
  endtask

  initial begin
    bus_a.sensor_in = 1'b0; bus_a.tick = 1'b0; bus_a.grant = 1'b0;
    bus_b.sensor_in = 1'b0; bus_b.tick = 1'b0; bus_b.grant = 1'b0;

    reset = 1'b0;
    step(3);
    expect_out("reset_a", 0, 1'b0, 1'b0, 3'd0, 1'b0);
    expect_out("reset_b", 1, 1'b0, 1'b0, 3'd0, 1'b0);
    compare_all();
    reset = 1'b1;

    bus_a.sensor_in = 1'b1;
    step(10);
    bus_a.sensor_in = 1'b0;
    step(30);
    expect_out("bounce_reject", 0, 1'b0, 1'b0, 3'd0, 1'b0);
    compare_all();

    bus_a.sensor_in = 1'b1;
    step(16);
    expect_out("clean_edge16", 0, 1'b0, 1'b0, 3'd0, 1'b0);
    compare_all();
    step(1);
    expect_out("clean_edge17", 0, 1'b1, 1'b0, 3'd0, 1'b0);
    compare_all();
    step(1);
    expect_out("request_rise", 0, 1'b1, 1'b1, 3'd1, 1'b0);
    compare_all();
    bus_a.sensor_in = 1'b0;
    step(20);
    expect_out("request_held", 0, 1'b0, 1'b1, 3'd1, 1'b0);
    compare_all();

    bus_a.grant = 1'b1;
    step(1);
    expect_out("grant_serve", 0, 1'b0, 1'b0, 3'd0, 1'b0);
    compare_all();
    tick_a();
    repeat (3) press_a();
    expect_out("press_in_serve", 0, 1'b0, 1'b0, 3'd0, 1'b0);
    compare_all();

    bus_a.grant = 1'b0;
    step(1);
    expect_out("holdoff_enter", 0, 1'b0, 1'b0, 3'd0, 1'b1);
    compare_all();
    bus_a.grant = 1'b1;
    press_a();
    bus_a.grant = 1'b0;
    expect_out("press_in_holdoff", 0, 1'b0, 1'b0, 3'd1, 1'b1);
    compare_all();
    tick_a();
    step(2);
    tick_a();
    expect_out("holdoff_tick2", 0, 1'b0, 1'b0, 3'd1, 1'b1);
    compare_all();
    tick_a();
    expect_out("holdoff_to_req", 0, 1'b0, 1'b1, 3'd1, 1'b0);
    compare_all();

    bus_a.grant = 1'b1;
    step(1);
    bus_a.grant = 1'b0;
    step(1);
    expect_out("holdoff_again", 0, 1'b0, 1'b0, 3'd0, 1'b1);
    compare_all();
    repeat (3) tick_a();
    expect_out("holdoff_to_idle", 0, 1'b0, 1'b0, 3'd0, 1'b0);
    compare_all();
    tick_a();
    expect_out("tick_in_idle", 0, 1'b0, 1'b0, 3'd0, 1'b0);
    compare_all();

    repeat (9) press_a();
    expect_out("saturate", 0, 1'b0, 1'b1, 3'd7, 1'b0);
    compare_all();

    bus_a.sensor_in = 1'b1;
    step(17);
    bus_a.grant = 1'b1;
    step(1);
    expect_out("grant_with_rise", 0, 1'b1, 1'b0, 3'd0, 1'b0);
    compare_all();
    bus_a.sensor_in = 1'b0;
    step(20);

    bus_a.grant = 1'b0;
    step(1);
    repeat (5) press_a();
    expect_out("holdoff_pend5", 0, 1'b0, 1'b0, 3'd5, 1'b1);
    compare_all();
    reset = 1'b0;
    step(1);
    expect_out("reset_midop", 0, 1'b0, 1'b0, 3'd0, 1'b0);
    compare_all();
    reset = 1'b1;
    tick_a();
    step(3);
    expect_out("after_reset_idle", 0, 1'b0, 1'b0, 3'd0, 1'b0);
    compare_all();

    bus_b.sensor_in = 1'b1;
    step(6);
    expect_out("b_request", 1, 1'b1, 1'b1, 3'd1, 1'b0);
    compare_all();
    bus_b.sensor_in = 1'b0;
    step(6);
    bus_b.grant = 1'b1;
    step(1);
    expect_out("b_serve", 1, 1'b0, 1'b0, 3'd0, 1'b0);
    compare_all();
    bus_b.grant = 1'b0;
    step(1);
    expect_out("b_serve_to_idle", 1, 1'b0, 1'b0, 3'd0, 1'b0);
    expect_out("b_never_holdoff", 2, 1'b0, 1'b0, 3'd0, 1'b0);
    compare_all();
    bus_b.sensor_in = 1'b1;
    step(6);
    expect_out("b_idle_again_req", 1, 1'b1, 1'b1, 3'd1, 1'b0);
    compare_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crossroad_request_detector.md
Name: crossroad_request_detector

Overview:
Upstream conditioning stage for the traffic light controller. It synchronises and debounces the raw crossroad vehicle-sensor switch and counts vehicle arrivals. It raises a latched service request to the controller, drops it on grant, then enforces a hold-off period before it can re-request. The arrival count is exported for the seven-segment display path.

Parameters:
DB_COUNT, 15, number of consecutive clk cycles the synchronised sensor must disagree with sensor_clean before sensor_clean updates; legal range 1..255
DB_W, 8, width of the debounce counter; must hold DB_COUNT
HOLDOFF_TICKS, 3, number of tick pulses after grant falls before a new request may be raised; 0 disables hold-off; legal range 0..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
sensor_in  in  1  raw, asynchronous, bouncy vehicle-sensor switch
tick  in  1  one-clk-wide slow time-base enable pulse (e.g. from clock divider)
grant  in  1  level; high while controller serves crossroad green
sensor_clean  out  1  debounced sensor level
request  out  1  latched crossroad service request to controller
pending_count  out  3  vehicle arrivals since last service start, saturating at 7
holdoff  out  1  high while in HOLDOFF state

Behaviour:
- Reset (reset==0 at posedge clk): sync flops=0, debounce counter=0, sensor_clean=0, state=IDLE, pending_count=0, hold-off counter=0; request=0, holdoff=0. Reset is honoured mid-operation from any state.
- Synchroniser: two flops on sensor_in; sync2 is the second-stage output.
- Debounce, per clk:
  - if sync2==sensor_clean: counter<=0.
  - else if counter==DB_COUNT-1: sensor_clean<=sync2, counter<=0.
  - else: counter<=counter+1.
  - A stable input change appears on sensor_clean exactly DB_COUNT+2 clks after sensor_in changes.
  - Any excursion shorter than DB_COUNT sync2 cycles is ignored and restarts the count.
- rise: internal one-cycle pulse on sensor_clean 0->1.
- pending_count:
  - +1 on rise, saturating at 7, in states IDLE, REQ, HOLDOFF.
  - rise in SERVE is ignored.
  - Cleared to 0 on the REQ->SERVE transition; the clear wins over a simultaneous rise.
- FSM (registered outputs: request=(state==REQ), holdoff=(state==HOLDOFF)):
  - IDLE: rise -> REQ. grant ignored.
  - REQ: grant==1 -> SERVE. Otherwise stay; request stays high indefinitely.
  - SERVE: grant==0 -> HOLDOFF, loading hold-off counter=HOLDOFF_TICKS. If HOLDOFF_TICKS==0, go to REQ if pending_count>0, else IDLE.
  - HOLDOFF: decrement counter on tick. On the tick that brings the counter to 0, go to REQ if pending_count>0 (including a rise in that same cycle), else IDLE.
  - grant in HOLDOFF is ignored.
- Latency: request rises 1 clk after the rise cycle and falls 1 clk after grant is sampled high.
- tick with no effect outside HOLDOFF. tick and grant are sampled only at posedge clk.

Test Plan:
- Reset and bounce reject: hold reset=0 for 3 clks -> all outputs 0. Release. With DB_COUNT=15, pulse sensor_in high for 10 clks, then low -> sensor_clean, request and pending_count stay 0.
- Clean press: sensor_in 0->1 held -> sensor_clean=1 exactly 17 clks later. request=1 and pending_count=1 on the following clk.
- Grant handshake: in REQ, drive grant=1 -> next clk request=0, pending_count=0. Three presses during grant -> pending_count remains 0.
- Hold-off: drop grant -> holdoff=1. One press during hold-off -> pending_count=1, request=0. After the 3rd tick, holdoff=0 and request=1 on the same clk. Repeat with no press -> return to IDLE with request=0.
- Saturation and simultaneity: 9 presses while in REQ -> pending_count=7. Assert grant in the same cycle as a rise -> pending_count=0, state SERVE.
- Reset mid-operation: assert reset=0 during HOLDOFF with pending_count=5 -> next clk all outputs 0 and state IDLE. Run HOLDOFF_TICKS=0 variant -> SERVE leads directly to IDLE or REQ with holdoff never asserted.
